// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed 7-segment scanner for packed BCD digits
// Optional leading-zero blanking: define BCD_DISPLAY_LZB_EN.
module bcd_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]             prescaler_q, prescaler_d;
    logic [IW-1:0]             index_q, index_d;
    logic [4*NUM_DIGITS-1:0]   staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0]   display_q, display_d;
    logic                      pending_q, pending_d;
    logic                      load_ack_q, load_ack_d;
    logic                      frame_start_q, frame_start_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      tick;
    logic                      wrap;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q   <= '0;
            index_q       <= IDX_LAST;
            staging_q     <= '0;
            display_q     <= '0;
            pending_q     <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            staging_q     <= staging_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    // Timing and capture: a commit always takes the staging value from before this edge.
    always_comb begin
        tick          = (prescaler_q == PRE_LAST);
        wrap          = tick && (index_q == IDX_LAST);
        prescaler_d   = tick ? '0 : prescaler_q + PW'(1);
        index_d       = index_q;
        if (tick) begin
            index_d = (index_q == IDX_LAST) ? '0 : index_q + IW'(1);
        end
        staging_d     = staging_q;
        display_d     = display_q;
        pending_d     = pending_q;
        if (wrap && pending_q) begin
            display_d = staging_q;
            pending_d = 1'b0;
        end
        if (load) begin
            staging_d = digits_in;
            pending_d = 1'b1;
        end
        frame_start_d = wrap;
        load_ack_d    = wrap && pending_q;
    end

    // Output registers hold pin-level values so the pins are driven straight from flops.
    always_comb begin
        logic [3:0]            nib;
        logic [6:0]            seg_raw;
        logic [NUM_DIGITS-1:0] an_hot;
`ifdef BCD_DISPLAY_LZB_EN
        logic                  zero_run;
        logic [NUM_DIGITS-1:0] blank;
`endif
        an_d   = an_q;
        seg_d  = seg_q;
        nib    = display_d[{index_d, 2'b00} +: 4];
        an_hot = '0;
        an_hot[index_d] = 1'b1;
`ifdef BCD_DISPLAY_LZB_EN
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (display_d[4*k +: 4] == 4'd0);
            blank[k] = zero_run;
        end
        seg_raw = blank[index_d] ? 7'h00 : decode(nib);
`else
        seg_raw = decode(nib);
`endif
        if (tick) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            an_d  = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign seg         = seg_q;
    assign an          = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner (4 digits, SCAN_DIV=4)
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic        load_ack;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int ack_cnt;

    int          m_pre, m_idx;
    logic [15:0] m_stag, m_disp;
    bit          m_pend;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic [12:0] sb[$];

    bcd_display_scanner #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
        .load_ack(load_ack), .seg(seg), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

`ifdef BCD_DISPLAY_LZB_EN
    localparam logic [6:0] ZERO_HI = 7'h7F;
`else
    localparam logic [6:0] ZERO_HI = 7'h40;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_dec(input logic [3:0] n);
        logic [6:0] tbl[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (n > 4'd9) ? 7'h40 : tbl[n];
    endfunction

    function automatic logic [6:0] exp_pin_seg(input int k, input logic [15:0] disp);
        logic [15:0] upper;
        upper = disp >> (4 * k);
`ifdef BCD_DISPLAY_LZB_EN
        if (k > 0 && upper == 16'h0) return 7'h7F;
`endif
        return ~exp_dec(upper[3:0]);
    endfunction

    task automatic model_reset();
        m_pre = 0; m_idx = 3; m_stag = '0; m_disp = '0; m_pend = 0;
        m_an = 4'hF; m_seg = 7'h7F;
        sb.delete();
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] din);
        bit tick, wrap, ack;
        tick = (m_pre == 3);
        wrap = tick && (m_idx == 3);
        ack  = wrap && m_pend;
        if (ack) begin
            m_disp = m_stag;
            m_pend = 0;
        end
        if (ld) begin
            m_stag = din;
            m_pend = 1;
        end
        if (tick) begin
            m_idx = (m_idx + 1) % 4;
            m_an  = ~(4'b0001 << m_idx);
            m_seg = exp_pin_seg(m_idx, m_disp);
        end
        m_pre = tick ? 0 : m_pre + 1;
        sb.push_back({m_an, m_seg, wrap, ack});
    endtask

    task automatic step(input logic ld, input logic [15:0] din);
        logic [12:0] e;
        load = ld;
        digits_in = din;
        model_edge(ld, din);
        @(posedge clk);
        #1;
        load = 1'b0;
        e = sb.pop_front();
        check("an", 32'(an), 32'(e[12:9]));
        check("seg", 32'(seg), 32'(e[8:2]));
        check("frame_start", 32'(frame_start), 32'(e[1]));
        check("load_ack", 32'(load_ack), 32'(e[0]));
        if (load_ack) ack_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic wait_ack(input string tag);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, 16'h0);
            got = load_ack;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; digits_in = '0; ack_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ack", 32'(load_ack), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;

        // idle scan: first digit appears on the 4th edge
        idle(3);
        check("pre_tick_an", 32'(an), 32'hF);
        idle(1);
        check("first_an", 32'(an), 32'hE);
        check("first_fs", 32'(frame_start), 32'd1);
        check("first_seg", 32'(seg), 32'h40);
        idle(16);

        // load mid-frame, commit at the next wrap
        idle(5);
        step(1'b1, 16'h1234);
        idle(1);
        check("hold_old", 32'(seg), 32'(ZERO_HI));
        wait_ack("ack_1234");
        check("ack_fs", 32'(frame_start), 32'd1);
        check("d0_4", 32'(seg), 32'h19);
        idle(4);
        check("d1_3", 32'(seg), 32'h30);
        idle(4);
        check("d2_2", 32'(seg), 32'h24);
        idle(4);
        check("d3_1", 32'(seg), 32'h79);
        idle(4);

        // two loads in one frame: latest wins, one ack
        ack_cnt = 0;
        step(1'b1, 16'h1111);
        idle(3);
        step(1'b1, 16'h5678);
        idle(40);
        check("one_ack", 32'(ack_cnt), 32'd1);

        // load on the commit edge
        step(1'b1, 16'h1234);
        for (int i = 0; i < 20 && !(m_pre == 3 && m_idx == 3); i++) idle(1);
        ack_cnt = 0;
        step(1'b1, 16'h9999);
        check("edge_ack", 32'(load_ack), 32'd1);
        check("edge_seg_4", 32'(seg), 32'h19);
        idle(16);
        check("two_acks", 32'(ack_cnt), 32'd2);
        check("d0_9", 32'(seg), 32'h10);

        // invalid nibble and leading zeros
        step(1'b1, 16'h00A0);
        wait_ack("ack_00a0");
        check("a0_d0", 32'(seg), 32'h40);
        idle(4);
        check("a0_dash", 32'(seg), 32'h3F);
        idle(4);
        check("a0_d2", 32'(seg), 32'(ZERO_HI));
        idle(4);
        check("a0_d3", 32'(seg), 32'(ZERO_HI));

        // reset mid-slot with a load pending
        idle(1);
        step(1'b1, 16'h5555);
        idle(1);
        reset = 1'b1;
        #2;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_ack", 32'(load_ack), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        ack_cnt = 0;
        idle(4);
        check("post_rst_an", 32'(an), 32'hE);
        check("post_rst_seg", 32'(seg), 32'h40);
        idle(36);
        check("post_rst_noack", 32'(ack_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
